// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling FSM and a
// fixed-width rs_clk strobe that tells the downstream stage a new byte is ready.
module uart_rx_byte #(
    parameter int BAUD_DIV = 434,
    parameter int STB_LEN  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rs_data,
    output logic       rs_clk,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [15:0] HALF_BIT = 16'(BAUD_DIV / 2 - 1);
    localparam logic [15:0] FULL_BIT = 16'(BAUD_DIV - 1);
    localparam logic [2:0]  STB_CYC  = 3'(STB_LEN);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        rx_meta;
    logic        rxs;
    logic        rxs_prev;
    logic [15:0] timer;
    logic [15:0] timer_nx;
    logic [2:0]  idx;
    logic [2:0]  idx_nx;
    logic [7:0]  shift_reg;
    logic [7:0]  shift_nx;
    logic        byte_ok;
    logic        ferr_nx;
    logic        timer_zero;
    logic [2:0]  stb_cnt;

    assign timer_zero = (timer == 16'd0);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta   <= 1'b1;
            rxs       <= 1'b1;
            rxs_prev  <= 1'b1;
            state     <= IDLE;
            timer     <= 16'd0;
            idx       <= 3'd0;
            shift_reg <= 8'h00;
            rs_data   <= 8'h00;
            rs_clk    <= 1'b0;
            stb_cnt   <= 3'd0;
            frame_err <= 1'b0;
        end else begin
            rx_meta   <= rxd;
            rxs       <= rx_meta;
            rxs_prev  <= rxs;
            state     <= state_nx;
            timer     <= timer_nx;
            idx       <= idx_nx;
            shift_reg <= shift_nx;
            frame_err <= ferr_nx;
            if (byte_ok) begin
                rs_data <= shift_reg;
            end
            // Strobe runs on its own so a new frame can start while it is high.
            if (byte_ok) begin
                stb_cnt <= STB_CYC;
                rs_clk  <= 1'b1;
            end else if (stb_cnt != 3'd0) begin
                stb_cnt <= stb_cnt - 3'd1;
                rs_clk  <= (stb_cnt > 3'd1);
            end
        end
    end

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        idx_nx   = idx;
        shift_nx = shift_reg;
        byte_ok  = 1'b0;
        ferr_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (rxs_prev && !rxs) begin
                    state_nx = START;
                    timer_nx = HALF_BIT;
                end
            end
            START: begin
                if (!timer_zero) begin
                    timer_nx = timer - 16'd1;
                end else if (!rxs) begin
                    state_nx = DATA;
                    timer_nx = FULL_BIT;
                    idx_nx   = 3'd0;
                end else begin
                    state_nx = IDLE;
                end
            end
            DATA: begin
                if (!timer_zero) begin
                    timer_nx = timer - 16'd1;
                end else begin
                    shift_nx[idx] = rxs;
                    timer_nx      = FULL_BIT;
                    if (idx == 3'd7) begin
                        state_nx = STOP;
                    end else begin
                        idx_nx = idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (!timer_zero) begin
                    timer_nx = timer - 16'd1;
                end else if (rxs) begin
                    byte_ok  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    ferr_nx  = 1'b1;
                    state_nx = WAIT_IDLE;
                    timer_nx = FULL_BIT;
                end
            end
            WAIT_IDLE: begin
                // Any low sample restarts the full-bit count of idle line.
                if (!rxs) begin
                    timer_nx = FULL_BIT;
                end else if (timer_zero) begin
                    state_nx = IDLE;
                end else begin
                    timer_nx = timer - 16'd1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule
